// File: rtl/mem_bus_arbiter_if.sv
// Bundle of core-side and memory-side signals for the shared memory port arbiter.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [3:0]              req;
  logic [4*ADDR_WIDTH-1:0] req_inst;
  logic [4*DATA_WIDTH-1:0] req_wdata;
  logic [3:0]              grant;
  logic [3:0]              stall;
  logic [3:0]              done;
  logic [3:0]              err;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    mem_req;
  logic [ADDR_WIDTH-1:0]   mem_inst;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_ack;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    busy;

  // Arbiter side
  modport slave (
    input  req, req_inst, req_wdata, mem_ack, mem_rdata,
    output grant, stall, done, err, rdata, mem_req, mem_inst, mem_wdata, busy
  );

  // Environment side: cores plus downstream memory
  modport master (
    output req, req_inst, req_wdata, mem_ack, mem_rdata,
    input  grant, stall, done, err, rdata, mem_req, mem_inst, mem_wdata, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one downstream memory port among four L1 caches,
// with a saturating watchdog that aborts hung transactions.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input logic              plusclk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int unsigned WdWidth = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WdWidth-1:0] WdLast =
      (TIMEOUT_CYC > 0) ? WdWidth'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {StIdle, StMem, StResp, StErr} state_e;

  state_e                state_q, state_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [1:0]            gidx_q, gidx_d;
  logic [ADDR_WIDTH-3:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [WdWidth-1:0]    wdog_q, wdog_d;

  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [3:0] grant_oh, done_oh, err_oh;

  // Round-robin pick: first set req scanning from rr_ptr upward, wrapping mod 4
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_ptr_q;
    for (int i = 0; i < 4; i++) begin
      if (!pick_valid && bus.req[rr_ptr_q + 2'(i)]) begin
        pick_valid = 1'b1;
        pick_idx   = rr_ptr_q + 2'(i);
      end
    end
  end

  // Next-state logic for the FSM, latched transaction and watchdog
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    inst_d   = inst_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wdog_d   = wdog_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gidx_d  = pick_idx;
          // proc_id bits are dropped; the granted index replaces them downstream
          inst_d  = bus.req_inst[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH-2];
          wdata_d = bus.req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          wdog_d  = '0;
          state_d = StMem;
        end
      end
      StMem: begin
        // Ack has priority over a timeout landing in the same cycle
        if (bus.mem_ack) begin
          rdata_d = bus.mem_rdata;
          state_d = StResp;
        end else if (TIMEOUT_CYC != 0 && wdog_q == WdLast) begin
          state_d = StErr;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StResp, StErr: begin
        rr_ptr_d = gidx_q + 2'd1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge plusclk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= 2'd0;
      gidx_q   <= 2'd0;
      inst_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      inst_q   <= inst_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wdog_q   <= wdog_d;
    end
  end

  // One-hot grant/done/err decoded from state and granted index
  always_comb begin
    grant_oh = '0;
    done_oh  = '0;
    err_oh   = '0;
    if (state_q == StMem)  grant_oh[gidx_q] = 1'b1;
    if (state_q == StResp) done_oh[gidx_q]  = 1'b1;
    if (state_q == StErr)  err_oh[gidx_q]   = 1'b1;
  end

  assign bus.grant     = grant_oh;
  assign bus.stall     = bus.req & ~grant_oh;
  assign bus.done      = done_oh;
  assign bus.err       = err_oh;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = (state_q == StMem);
  assign bus.mem_inst  = {gidx_q, inst_q};
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
